// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the prefetch queue: fetch FSM encoding and
// elaboration-time parameter legality helper.
package prefetch_queue_pkg;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    function automatic bit depth_is_legal(input int unsigned depth);
        return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/prefetch_queue_hs_sync.sv
// Multi-flop synchroniser for one toggle-handshake bit; clears to 0 on reset
// so both handshake phases realign with the peers.
module prefetch_queue_hs_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch stage between instruction ROM and issuer: fetches sequential words
// into a small queue via toggle handshakes and serves issuer requests from it.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH       = 4,
    parameter int unsigned       PC_STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flushIn,
    input  logic [ADDR_W-1:0]       pcIn,
    output logic [ADDR_W-1:0]       addrOut,
    output logic                    triggerOut,
    input  logic                    readyIn,
    input  logic [DATA_W-1:0]       dataIn,
    input  logic                    triggerIn,
    output logic                    readyOut,
    output logic [DATA_W-1:0]       dataOut,
    output logic [ADDR_W-1:0]       pcOut,
    output logic [$clog2(DEPTH):0]  countOut
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    if (!depth_is_legal(DEPTH) || (SYNC_STAGES < 32'd1) || (ADDR_W < 32'd1)) begin : g_param_check
        $error("prefetch_queue: DEPTH must be a power of 2 >= 2, SYNC_STAGES >= 1");
    end

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic              discard_r;

    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;

    logic rdy_s;
    logic trg_s;
    logic ack_s;
    logic push_s;
    logic pop_s;
    logic issue_s;

    prefetch_queue_hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (readyIn),
        .q     (rdy_s)
    );

    prefetch_queue_hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_trg_sync (
        .clk   (clk),
        .reset (reset),
        .d     (triggerIn),
        .q     (trg_s)
    );

    // Flush cancels any push or pop in its cycle; a word acked while discarding is dropped.
    assign ack_s   = (state_r == FETCH_WAIT) && (rdy_s == triggerOut);
    assign push_s  = ack_s && !discard_r && !flushIn;
    assign pop_s   = (trg_s != readyOut) && (countOut != {CNT_W{1'b0}}) && !flushIn;
    assign issue_s = (state_r == FETCH_IDLE) && (countOut < CNT_FULL) && !flushIn;

    // Fetch FSM: one outstanding ROM request at a time, plus fetch PC tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= FETCH_IDLE;
            addrOut    <= {ADDR_W{1'b0}};
            triggerOut <= 1'b0;
            discard_r  <= 1'b0;
            fetch_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                FETCH_IDLE: begin
                    if (issue_s) begin
                        addrOut    <= fetch_pc_r;
                        triggerOut <= ~triggerOut;
                        state_r    <= FETCH_WAIT;
                    end else begin
                        state_r    <= FETCH_IDLE;
                    end
                end
                FETCH_WAIT: begin
                    if (ack_s) begin
                        state_r   <= FETCH_IDLE;
                        discard_r <= 1'b0;
                    end else if (flushIn) begin
                        discard_r <= 1'b1;
                    end else begin
                        state_r   <= FETCH_WAIT;
                    end
                end
                default: begin
                    state_r   <= FETCH_IDLE;
                    discard_r <= 1'b0;
                end
            endcase

            if (flushIn) begin
                fetch_pc_r <= pcIn;
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(PC_STEP);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= dataIn;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            countOut <= {CNT_W{1'b0}};
        end else if (flushIn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            countOut <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   countOut <= countOut + CNT_ONE;
                2'b01:   countOut <= countOut - CNT_ONE;
                default: countOut <= countOut;
            endcase
        end
    end

    // Issuer side: deliver the head word and acknowledge by toggling readyOut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readyOut <= 1'b0;
            dataOut  <= {DATA_W{1'b0}};
            pcOut    <= {ADDR_W{1'b0}};
        end else if (pop_s) begin
            readyOut <= ~readyOut;
            dataOut  <= data_mem_r[rd_ptr_r];
            pcOut    <= pc_mem_r[rd_ptr_r];
        end else begin
            readyOut <= readyOut;
        end
    end

endmodule
